// File: rtl/register_flag_bank.sv
// register_flag_bank: NFLAGS status flags with per-flag one-hot source select, bus load and a DEPTH-entry shadow stack.
// Optional multi-hot select detection is enabled by defining REGISTER_FLAG_BANK_SELERR_EN.
module register_flag_bank #(
  parameter int NFLAGS = 8,
  parameter int NSRC = 8,
  parameter int DEPTH = 2,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic                   Clk,
  input  logic                   notReset,
  input  logic [NFLAGS*NSRC-1:0] FlagSrc,
  input  logic [NFLAGS*NSRC-1:0] Sel,
  input  logic [NFLAGS-1:0]      Write,
  input  logic                   BusWrite,
  input  logic [NFLAGS-1:0]      BusData,
  input  logic                   Push,
  input  logic                   Pop,
  output logic [NFLAGS-1:0]      Flags,
  output logic [NFLAGS-1:0]      notFlags,
  output logic [LW-1:0]          Level,
  output logic                   ShadowEmpty,
  output logic                   ShadowFull,
  output logic                   Overflow,
  output logic                   Underflow,
  output logic                   SelErr
);
  // Sized to the full Level range so Level can index it without width conversion.
  logic [NFLAGS-1:0] stack [2**LW];
  logic [LW-1:0] top;
  logic do_pop, do_push, swap;
  logic [NFLAGS-1:0] upd, nxt;
  assign ShadowEmpty = Level == '0;
  assign ShadowFull = Level == LW'(DEPTH);
  assign top = Level - LW'(1);
  assign do_pop = Pop && !ShadowEmpty;
  assign swap = do_pop && Push;
  assign do_push = Push && !ShadowFull && !do_pop;
  assign nxt = BusWrite ? BusData : do_pop ? stack[top] : upd;
`ifdef REGISTER_FLAG_BANK_SELERR_EN
  logic [NFLAGS-1:0] bad;
`endif
  for (genvar i = 0; i < NFLAGS; i++) begin : g_flag
    logic [NSRC-1:0] s, v;
    assign s = Sel[i*NSRC +: NSRC];
    assign v = FlagSrc[i*NSRC +: NSRC];
`ifdef REGISTER_FLAG_BANK_SELERR_EN
    assign bad[i] = Write[i] && |(s & (s - NSRC'(1)));
    assign upd[i] = (Write[i] && !bad[i]) ? |(s & v) : Flags[i];
`else
    assign upd[i] = Write[i] ? |(s & v) : Flags[i];
`endif
  end
  always_ff @(posedge Clk) begin
    if (!notReset) begin
      Flags <= '0;
      notFlags <= '1;
      Level <= '0;
      Overflow <= 1'b0;
      Underflow <= 1'b0;
    end else begin
      Flags <= nxt;
      notFlags <= ~nxt;
      Level <= do_push ? Level + LW'(1) : (do_pop && !swap) ? top : Level;
      Overflow <= Overflow | (Push && ShadowFull && !Pop);
      Underflow <= Underflow | (Pop && ShadowEmpty);
    end
  end
  // A swap overwrites the entry being restored with the pre-update flags.
  always_ff @(posedge Clk)
    if (notReset && (do_push || swap)) stack[swap ? top : Level] <= Flags;
`ifdef REGISTER_FLAG_BANK_SELERR_EN
  always_ff @(posedge Clk)
    if (!notReset) SelErr <= 1'b0;
    else SelErr <= SelErr | (|bad);
`else
  assign SelErr = 1'b0;
`endif
endmodule

// File: tb/tb_register_flag_bank.sv
// tb_register_flag_bank: directed vectors with a scoreboard queue checked by a separate monitor.
module tb_register_flag_bank;
  logic Clk = 1'b0;
  logic notReset = 1'b0;
  logic [63:0] FlagSrc = '0, Sel = '0;
  logic [7:0] Write = '0, BusData = '0;
  logic BusWrite = 1'b0, Push = 1'b0, Pop = 1'b0;
  logic [7:0] Flags, notFlags;
  logic [1:0] Level;
  logic ShadowEmpty, ShadowFull, Overflow, Underflow, SelErr;
  int checks = 0;
  int errors = 0;
  typedef struct {
    string name;
    logic [22:0] exp;
  } exp_t;
  exp_t q[$];

  register_flag_bank #(.NFLAGS(8), .NSRC(8), .DEPTH(2)) dut (
    .Clk(Clk), .notReset(notReset), .FlagSrc(FlagSrc), .Sel(Sel), .Write(Write),
    .BusWrite(BusWrite), .BusData(BusData), .Push(Push), .Pop(Pop),
    .Flags(Flags), .notFlags(notFlags), .Level(Level), .ShadowEmpty(ShadowEmpty),
    .ShadowFull(ShadowFull), .Overflow(Overflow), .Underflow(Underflow), .SelErr(SelErr)
  );

  always #5 Clk = ~Clk;

`ifdef REGISTER_FLAG_BANK_SELERR_EN
  localparam logic [7:0] MULTI_F = 8'h02;
  localparam logic MULTI_E = 1'b1;
`else
  localparam logic [7:0] MULTI_F = 8'h03;
  localparam logic MULTI_E = 1'b0;
`endif

  function automatic logic [63:0] rep(input logic [7:0] grp, input logic [7:0] mask);
    logic [63:0] r = '0;
    for (int f = 0; f < 8; f++) if (mask[f]) r[f*8 +: 8] = grp;
    return r;
  endfunction

  task automatic step(input string name, input logic rn, input logic bw, input logic [7:0] bd,
                      input logic pu, input logic po, input logic [7:0] wr, input logic [63:0] sl,
                      input logic [63:0] src, input logic [7:0] ef, input logic [1:0] el,
                      input logic eo, input logic eu, input logic es);
    exp_t e;
    @(negedge Clk);
    notReset = rn; BusWrite = bw; BusData = bd; Push = pu; Pop = po;
    Write = wr; Sel = sl; FlagSrc = src;
    @(posedge Clk);
    e.name = name;
    e.exp = {ef, ~ef, el, el == 2'd0, el == 2'd2, eo, eu, es};
    q.push_back(e);
  endtask

  initial forever begin
    @(negedge Clk);
    while (q.size() > 0) begin
      exp_t e;
      logic [22:0] obs;
      e = q.pop_front();
      obs = {Flags, notFlags, Level, ShadowEmpty, ShadowFull, Overflow, Underflow, SelErr};
      checks++;
      if (obs !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h (Flags,notFlags,Level,Empty,Full,Ovf,Unf,SelErr)", e.name, obs, e.exp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] oh3, odd;
    oh3 = rep(8'h08, 8'hFF);
    odd = rep(8'h08, 8'h55);
    //    name            rn bw bd     pu po wr     sel       src      F      L  ovf unf se
    step("reset",         0, 0, 8'h00, 0, 0, 8'h00, '0,       '0,      8'h00, 0, 0, 0, 0);
    step("onehot_all",    1, 0, 8'h00, 0, 0, 8'hFF, oh3,      oh3,     8'hFF, 0, 0, 0, 0);
    step("onehot_mix",    1, 0, 8'h00, 0, 0, 8'hFF, oh3,      odd,     8'h55, 0, 0, 0, 0);
    step("partial_wr",    1, 0, 8'h00, 0, 0, 8'h0F, oh3,      oh3,     8'h5F, 0, 0, 0, 0);
    step("bus_5a",        1, 1, 8'h5A, 0, 0, 8'h00, '0,       '0,      8'h5A, 0, 0, 0, 0);
    step("push_5a",       1, 0, 8'h00, 1, 0, 8'h00, '0,       '0,      8'h5A, 1, 0, 0, 0);
    step("bus_wins",      1, 1, 8'h81, 0, 1, 8'hFF, oh3,      oh3,     8'h81, 0, 0, 0, 0);
    step("bus_11",        1, 1, 8'h11, 0, 0, 8'h00, '0,       '0,      8'h11, 0, 0, 0, 0);
    step("push_11",       1, 0, 8'h00, 1, 0, 8'h00, '0,       '0,      8'h11, 1, 0, 0, 0);
    step("bus_22",        1, 1, 8'h22, 0, 0, 8'h00, '0,       '0,      8'h22, 1, 0, 0, 0);
    step("push_22",       1, 0, 8'h00, 1, 0, 8'h00, '0,       '0,      8'h22, 2, 0, 0, 0);
    step("bus_33",        1, 1, 8'h33, 0, 0, 8'h00, '0,       '0,      8'h33, 2, 0, 0, 0);
    step("push_full",     1, 0, 8'h00, 1, 0, 8'h00, '0,       '0,      8'h33, 2, 1, 0, 0);
    step("pop_22",        1, 0, 8'h00, 0, 1, 8'h00, '0,       '0,      8'h22, 1, 1, 0, 0);
    step("pop_11",        1, 0, 8'h00, 0, 1, 8'h00, '0,       '0,      8'h11, 0, 1, 0, 0);
    step("bus_0f",        1, 1, 8'h0F, 0, 0, 8'h00, '0,       '0,      8'h0F, 0, 1, 0, 0);
    step("push_0f",       1, 0, 8'h00, 1, 0, 8'h00, '0,       '0,      8'h0F, 1, 1, 0, 0);
    step("bus_f0",        1, 1, 8'hF0, 0, 0, 8'h00, '0,       '0,      8'hF0, 1, 1, 0, 0);
    step("swap",          1, 0, 8'h00, 1, 1, 8'h00, '0,       '0,      8'h0F, 1, 1, 0, 0);
    step("pop_swapped",   1, 0, 8'h00, 0, 1, 8'h00, '0,       '0,      8'hF0, 0, 1, 0, 0);
    step("pop_empty",     1, 0, 8'h00, 0, 1, 8'h00, '0,       '0,      8'hF0, 0, 1, 1, 0);
    step("push_a",        1, 0, 8'h00, 1, 0, 8'h00, '0,       '0,      8'hF0, 1, 1, 1, 0);
    step("push_b",        1, 0, 8'h00, 1, 0, 8'h00, '0,       '0,      8'hF0, 2, 1, 1, 0);
    step("reset_mid",     0, 1, 8'hAA, 1, 0, 8'hFF, oh3,      oh3,     8'h00, 0, 0, 0, 0);
    step("bus_3c",        1, 1, 8'h3C, 0, 0, 8'h00, '0,       '0,      8'h3C, 0, 0, 0, 0);
    step("pushpop_empty", 1, 0, 8'h00, 1, 1, 8'h00, '0,       '0,      8'h3C, 1, 0, 1, 0);
    step("bus_77",        1, 1, 8'h77, 0, 0, 8'h00, '0,       '0,      8'h77, 1, 0, 1, 0);
    step("pop_3c",        1, 0, 8'h00, 0, 1, 8'h00, '0,       '0,      8'h3C, 0, 0, 1, 0);
    step("zero_sel",      1, 0, 8'h00, 0, 0, 8'hFF, '0,       oh3,     8'h00, 0, 0, 1, 0);
    step("multi_hot",     1, 0, 8'h00, 0, 0, 8'h03, 64'h0105, 64'h0101, MULTI_F, 0, 0, 1, MULTI_E);
    step("reset_end",     0, 0, 8'h00, 0, 0, 8'h00, '0,       '0,      8'h00, 0, 0, 0, 0);
    repeat (3) @(negedge Clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
